// File: rtl/ram64_loader.sv
// ram64_loader: fills a 64 x 16 RAM64 from an 8-bit valid/ready byte stream.
// Big-endian byte pairs become words written to addresses 0..N-1, then every
// written word is read back and its sum compared against the write sum.
module ram64_loader (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [6:0]  count,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic        byte_ready,
   output logic [15:0] ram_in,
   output logic [5:0]  ram_sel,
   output logic        ram_load,
   input  logic [15:0] ram_out,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [15:0] checksum
);

   localparam logic [2:0] st_idle   = 3'd0;
   localparam logic [2:0] st_hi     = 3'd1;
   localparam logic [2:0] st_lo     = 3'd2;
   localparam logic [2:0] st_write  = 3'd3;
   localparam logic [2:0] st_verify = 3'd4;
   localparam logic [2:0] st_done   = 3'd5;

   logic [2:0]  state_q, state_d;
   logic [6:0]  n_q, n_d;
   logic [5:0]  addr_q, addr_d;
   logic [15:0] data_q, data_d;
   logic [15:0] wsum_q, wsum_d;
   logic [15:0] vsum_q, vsum_d;
   logic        error_q, error_d;
   // Last values driven to RAM64, held while not writing or verifying
   logic [15:0] in_hold_q, in_hold_d;
   logic [5:0]  sel_hold_q, sel_hold_d;
   logic        last;

   // addr never exceeds N-1, so N = 64 stops at 63 without a 7-bit address
   assign last = ({1'b0, addr_q} == (n_q - 7'd1));

   // Next-state and datapath updates
   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      addr_d     = addr_q;
      data_d     = data_q;
      wsum_d     = wsum_q;
      vsum_d     = vsum_q;
      error_d    = error_q;
      in_hold_d  = in_hold_q;
      sel_hold_d = sel_hold_q;
      case (state_q)
         st_idle: begin
            if (start) begin
               n_d     = (count > 7'd64) ? 7'd64 : count;
               addr_d  = 6'd0;
               wsum_d  = 16'h0000;
               vsum_d  = 16'h0000;
               error_d = 1'b0;
               state_d = (count == 7'd0) ? st_done : st_hi;
            end
         end
         st_hi: begin
            if (byte_valid) begin
               data_d[15:8] = byte_in;
               state_d      = st_lo;
            end
         end
         st_lo: begin
            if (byte_valid) begin
               data_d[7:0] = byte_in;
               state_d     = st_write;
            end
         end
         st_write: begin
            wsum_d     = wsum_q + data_q;
            in_hold_d  = data_q;
            sel_hold_d = addr_q;
            if (last) begin
               addr_d  = 6'd0;
               state_d = st_verify;
            end else begin
               addr_d  = addr_q + 6'd1;
               state_d = st_hi;
            end
         end
         st_verify: begin
            vsum_d     = vsum_q + ram_out;
            sel_hold_d = addr_q;
            if (last) begin
               error_d = ((vsum_q + ram_out) != wsum_q);
               state_d = st_done;
            end else begin
               addr_d = addr_q + 6'd1;
            end
         end
         st_done: state_d = st_idle;
         default: state_d = st_idle;
      endcase
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= st_idle;
         n_q        <= 7'd0;
         addr_q     <= 6'd0;
         data_q     <= 16'h0000;
         wsum_q     <= 16'h0000;
         vsum_q     <= 16'h0000;
         error_q    <= 1'b0;
         in_hold_q  <= 16'h0000;
         sel_hold_q <= 6'd0;
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         wsum_q     <= wsum_d;
         vsum_q     <= vsum_d;
         error_q    <= error_d;
         in_hold_q  <= in_hold_d;
         sel_hold_q <= sel_hold_d;
      end
   end

   // Outputs decoded from state and registers only
   always_comb begin
      byte_ready = (state_q == st_hi) || (state_q == st_lo);
      ram_load   = (state_q == st_write);
      ram_in     = (state_q == st_write) ? data_q : in_hold_q;
      ram_sel    = ((state_q == st_write) || (state_q == st_verify)) ? addr_q : sel_hold_q;
      busy       = (state_q != st_idle) && (state_q != st_done);
      done       = (state_q == st_done);
      error      = error_q;
      checksum   = wsum_q;
   end

endmodule

// File: tb/tb_ram64_loader.sv
// Scoreboard bench for ram64_loader with a behavioural RAM64 model.
module tb_ram64_loader;

   logic        clk = 1'b0;
   logic        reset, start, byte_valid;
   logic [6:0]  count;
   logic [7:0]  byte_in;
   logic        byte_ready, ram_load, busy, done, error;
   logic [15:0] ram_in, ram_out, checksum;
   logic [5:0]  ram_sel;

   logic [15:0] mem [64];
   logic        stuck = 1'b0;
   logic [15:0] wl [64];
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;

   typedef struct {int cyc; logic [5:0] sel; logic [15:0] data;} wr_t;
   typedef struct {int cyc; logic [15:0] sum; logic err;} dn_t;
   wr_t wq[$];
   dn_t dq[$];

   ram64_loader dut (
      .clk(clk), .reset(reset), .start(start), .count(count),
      .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
      .ram_in(ram_in), .ram_sel(ram_sel), .ram_load(ram_load), .ram_out(ram_out),
      .busy(busy), .done(done), .error(error), .checksum(checksum)
   );

   // RAM64 model, optional stuck-at-1 on read bit 0
   assign ram_out = mem[ram_sel] | {15'd0, stuck};
   always @(posedge clk) if (ram_load) mem[ram_sel] <= ram_in;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Monitor: pops expectations whenever the DUT writes or signals done
   always @(negedge clk) begin
      wr_t w;
      dn_t d;
      if (ram_load) begin
         if (wq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_write: sel %0d data %0h at cycle %0d, none required",
                     ram_sel, ram_in, cyc);
         end else begin
            w = wq.pop_front();
            check("write_cycle", cyc, w.cyc);
            check("write_sel", 32'(ram_sel), 32'(w.sel));
            check("write_data", 32'(ram_in), 32'(w.data));
         end
      end
      if (done) begin
         if (dq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_done: done at cycle %0d, none required", cyc);
         end else begin
            d = dq.pop_front();
            check("done_cycle", cyc, d.cyc);
            check("checksum", 32'(checksum), 32'(d.sum));
            check("error", 32'(error), 32'(d.err));
            check("busy_at_done", 32'(busy), 32'd0);
         end
      end
   end

   task automatic put_byte(input logic [7:0] b, input int g);
      int w = 0;
      byte_valid = 1'b0;
      while (!byte_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (!byte_ready) begin
         n_cmp++; n_bad++;
         $display("FAIL byte_ready_timeout: byte_ready 0 after 50 cycles, 1 required");
      end
      repeat (g) @(negedge clk);
      byte_in    = b;
      byte_valid = 1'b1;
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int w = 0;
      while (dq.size() != 0 && w < 2000) begin
         @(negedge clk);
         w++;
      end
      if (dq.size() != 0) begin
         n_cmp++; n_bad++;
         $display("FAIL done_timeout: done missing after 2000 cycles, required");
         dq.delete();
         wq.delete();
      end
      @(negedge clk);
   endtask

   // Expectations are queued before the start edge, then the bytes are streamed
   task automatic run_load(input logic [6:0] c, input int nw, input int g, input logic e);
      int t0;
      logic [15:0] sum = 16'h0000;
      t0 = cyc + 1;
      for (int k = 0; k < nw; k++) begin
         wq.push_back('{t0 + (k + 1) * (3 + 2 * g) - 1, 6'(k), wl[k]});
         sum = sum + wl[k];
      end
      dq.push_back('{t0 + nw * (4 + 2 * g), sum, e});
      start = 1'b1;
      count = c;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < nw; k++) begin
         put_byte(wl[k][15:8], g);
         put_byte(wl[k][7:0], g);
      end
      wait_idle();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
      check({tag, "_ram_load"}, 32'(ram_load), 32'd0);
      check({tag, "_ram_in"}, 32'(ram_in), 32'd0);
      check({tag, "_ram_sel"}, 32'(ram_sel), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_error"}, 32'(error), 32'd0);
      check({tag, "_checksum"}, 32'(checksum), 32'd0);
   endtask

   initial begin
      int t0;
      int w;
      for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
      reset = 1'b1; start = 1'b0; count = 7'd0; byte_in = 8'h00; byte_valid = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check_reset_outputs("reset");

      // Three words, continuous bytes: AAAA + 1234 + DEAD = 9B8B
      wl[0] = 16'hAAAA; wl[1] = 16'h1234; wl[2] = 16'hDEAD;
      run_load(7'd3, 3, 0, 1'b0);
      check("readback0", 32'(mem[0]), 32'h0000AAAA);
      check("readback1", 32'(mem[1]), 32'h00001234);
      check("readback2", 32'(mem[2]), 32'h0000DEAD);

      // Same words, 5-cycle stall before every byte
      for (int i = 0; i < 3; i++) mem[i] = 16'h0000;
      run_load(7'd3, 3, 5, 1'b0);
      check("stall_readback2", 32'(mem[2]), 32'h0000DEAD);
      check("stall_checksum", 32'(checksum), 32'h00009B8B);

      // 64 words of value = index, checksum 0x07E0, then count 100 clamps to 64
      for (int i = 0; i < 64; i++) wl[i] = 16'(i);
      run_load(7'd64, 64, 0, 1'b0);
      check("readback63", 32'(mem[63]), 32'd63);
      run_load(7'd100, 64, 0, 1'b0);
      check("clamp_checksum", 32'(checksum), 32'h000007E0);

      // count 0: done right after start, no write, checksum cleared
      run_load(7'd0, 0, 0, 1'b0);

      // Stuck read bit: error set and sticky until the next start
      stuck = 1'b1;
      wl[0] = 16'h1234;
      run_load(7'd1, 1, 0, 1'b1);
      repeat (3) @(negedge clk);
      check("error_sticky", 32'(error), 32'd1);
      run_load(7'd0, 0, 0, 1'b0);
      stuck = 1'b0;

      // Reset in LO of word 2: words 0 and 1 land, then abort
      wl[0] = 16'h1111; wl[1] = 16'h2222; wl[2] = 16'h3333;
      t0 = cyc + 1;
      wq.push_back('{t0 + 2, 6'd0, 16'h1111});
      wq.push_back('{t0 + 5, 6'd1, 16'h2222});
      start = 1'b1; count = 7'd3;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 2; k++) begin
         put_byte(wl[k][15:8], 0);
         put_byte(wl[k][7:0], 0);
      end
      put_byte(8'h33, 0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_reset_outputs("abort");
      check("abort_mem2", 32'(mem[2]), 32'd2);
      check("abort_writes_pending", wq.size(), 0);

      // start held high while busy must not relatch count (2 words, sum 0x3333)
      t0 = cyc + 1;
      wq.push_back('{t0 + 2, 6'd0, 16'h1111});
      wq.push_back('{t0 + 5, 6'd1, 16'h2222});
      dq.push_back('{t0 + 8, 16'h3333, 1'b0});
      start = 1'b1; count = 7'd2;
      @(negedge clk);
      count = 7'd5;
      put_byte(8'h11, 0);
      put_byte(8'h11, 0);
      start = 1'b0;
      put_byte(8'h22, 0);
      put_byte(8'h22, 0);
      w = 0;
      while (!done && w < 100) begin
         @(negedge clk);
         w++;
      end
      // start during the DONE cycle is also ignored
      start = 1'b1; count = 7'd1;
      @(negedge clk);
      start = 1'b0;
      check("start_in_done_busy", 32'(busy), 32'd0);
      @(negedge clk);
      check("start_in_done_busy2", 32'(busy), 32'd0);
      check("start_in_done_ready", 32'(byte_ready), 32'd0);
      repeat (3) @(negedge clk);

      check("writes_outstanding", wq.size(), 0);
      check("dones_outstanding", dq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
